s3g_frame_tx: RTL and testbench

Response framer between the S3G command/interrupt logic and the UART transmitter.
- Upstream logic writes a reply payload byte-by-byte into an internal buffer and commits it.
- The block computes the S3G CRC-8 on the fly.
- It emits the complete frame to the UART transceiver byte interface: 0xD5, length, payload, CRC.
- Frames are sent one byte per tx_done handshake.

---
 rtl/s3g_frame_tx_if.sv | 24 ++
 rtl/s3g_frame_tx.sv | 161 ++++++++++++++++
 tb/tb_s3g_frame_tx.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/s3g_frame_tx_if.sv
// Byte-level interface of the S3G response framer: payload loading from the
// command logic plus the byte handshake towards the UART transceiver.
interface s3g_frame_tx_if;
  logic [7:0] pl_data;
  logic       pl_wr;
  logic       pl_commit;
  logic       pl_abort;
  logic       busy;
  logic       pkt_sent;
  logic       err_overflow;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_done;

  modport master (
    output pl_data, pl_wr, pl_commit, pl_abort, tx_done,
    input  busy, pkt_sent, err_overflow, tx_data, tx_wr
  );

  modport slave (
    input  pl_data, pl_wr, pl_commit, pl_abort, tx_done,
    output busy, pkt_sent, err_overflow, tx_data, tx_wr
  );
endinterface

// File: rtl/s3g_frame_tx.sv
// S3G response framer: buffers a payload, tracks its CRC-8 and sends
// D5 / length / payload / CRC to the UART one byte per tx_done handshake.
module s3g_frame_tx #(
  parameter int MAX_PAYLOAD = 32,
  parameter int LEN_W       = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  s3g_frame_tx_if.slave bus
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] SYNC = 3'd1;
  localparam logic [2:0] LEN  = 3'd2;
  localparam logic [2:0] DATA = 3'd3;
  localparam logic [2:0] CRC  = 3'd4;

  localparam int               AW        = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_PAYLOAD);
  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
  localparam logic [7:0]       SYNC_BYTE = 8'hD5;

  logic [2:0]       state;
  logic [LEN_W-1:0] length;
  logic [LEN_W-1:0] idx;
  logic [7:0]       crc;
  logic [7:0]       tx_data;
  logic             tx_wr;
  logic             pkt_sent;
  logic             err_overflow;
  logic [7:0]       buffer [2**AW];

  logic             idle;
  logic             done_ok;
  logic             abort_idle;
  logic             wr_accept;
  logic             wr_drop;
  logic             start_clr;
  logic             last_data;
  logic [LEN_W-1:0] idx_nxt;
  logic [7:0]       crc_nxt;

  // Reflected CRC-8 (poly 0x8C), LSB of the data byte first.
  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 8'h8C;
      else             r = r >> 1;
    end
    return r;
  endfunction

  assign idle       = (state == IDLE);
  // A tx_done in the same cycle as our own strobe cannot belong to that byte.
  assign done_ok    = bus.tx_done && !tx_wr && !idle;
  assign abort_idle = idle && bus.pl_abort;
  assign wr_accept  = idle && bus.pl_wr && !bus.pl_abort && (length < LEN_MAX);
  assign wr_drop    = bus.pl_wr && !wr_accept && !abort_idle;
  assign start_clr  = (state == SYNC) && tx_wr;
  assign idx_nxt    = idx + LEN_ONE;
  assign last_data  = (idx_nxt == length);
  assign crc_nxt    = crc8_byte(crc, bus.pl_data);

  // NOTE: the payload RAM has no reset; only length/crc decide what is valid.
  always_ff @(posedge clk) begin
    if (wr_accept) buffer[length[AW-1:0]] <= bus.pl_data;
  end

  // NOTE: all state registers use <= so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      length       <= '0;
      crc          <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (abort_idle) begin
        length <= '0;
        crc    <= '0;
      end else if (wr_accept) begin
        length <= length + LEN_ONE;
        crc    <= crc_nxt;
      end else if (state == CRC && done_ok) begin
        length <= '0;
        crc    <= '0;
      end

      if (abort_idle)     err_overflow <= 1'b0;
      else if (wr_drop)   err_overflow <= 1'b1;
      else if (start_clr) err_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      tx_data  <= '0;
      tx_wr    <= 1'b0;
      pkt_sent <= 1'b0;
    end else begin
      tx_wr    <= 1'b0;
      pkt_sent <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.pl_commit && !bus.pl_abort) begin
            state   <= SYNC;
            tx_wr   <= 1'b1;
            tx_data <= SYNC_BYTE;
          end
        end
        SYNC: begin
          if (done_ok) begin
            state   <= LEN;
            tx_wr   <= 1'b1;
            tx_data <= 8'(length);
          end
        end
        LEN: begin
          if (done_ok) begin
            tx_wr <= 1'b1;
            if (length == '0) begin
              state   <= CRC;
              tx_data <= crc;
            end else begin
              state   <= DATA;
              idx     <= '0;
              tx_data <= buffer[0];
            end
          end
        end
        DATA: begin
          if (done_ok) begin
            tx_wr <= 1'b1;
            if (last_data) begin
              state   <= CRC;
              tx_data <= crc;
            end else begin
              idx     <= idx_nxt;
              tx_data <= buffer[idx_nxt[AW-1:0]];
            end
          end
        end
        CRC: begin
          if (done_ok) begin
            state    <= IDLE;
            pkt_sent <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy         = !idle;
  assign bus.pkt_sent     = pkt_sent;
  assign bus.err_overflow = err_overflow;
  assign bus.tx_data      = tx_data;
  assign bus.tx_wr        = tx_wr;

endmodule

// File: tb/tb_s3g_frame_tx.sv
// Scoreboard bench for s3g_frame_tx: a queue-based frame model predicts every
// UART byte, and a monitor compares strobes, latencies and pkt_sent pulses.
module tb_s3g_frame_tx;
  localparam int MAX = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  s3g_frame_tx_if bus ();

  s3g_frame_tx #(.MAX_PAYLOAD(MAX), .LEN_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         n_checks   = 0;
  int         n_fail     = 0;
  int         cyc        = 0;
  logic [7:0] exp_q [$];
  logic [7:0] mdl_buf [$];
  logic       mdl_err    = 1'b0;
  logic       mdl_busy   = 1'b0;
  int         pkt_exp    = 0;
  int         commit_cyc = 0;
  int         last_done  = -10;
  bit         first_byte = 1'b0;
  int         bytes_seen = 0;
  int         resp_delay = 100;
  bit         rand_delay = 1'b0;
  int         resp_wait  = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] ref_crc(input logic [7:0] data [$]);
    logic [7:0] c;
    logic [7:0] b;
    c = 8'h00;
    foreach (data[k]) begin
      b = data[k];
      for (int i = 0; i < 8; i++) begin
        c = ((c ^ b) & 8'h01) != 0 ? ((c >> 1) ^ 8'h8C) : (c >> 1);
        b = b >> 1;
      end
    end
    return c;
  endfunction

  always @(posedge clk) cyc++;

  // UART responder: answers each strobe with a one-cycle tx_done after a delay.
  always @(posedge clk) begin
    #1;
    bus.tx_done = 1'b0;
    if (!rst_n) begin
      resp_wait = -1;
    end else if (resp_wait > 0) begin
      resp_wait--;
      if (resp_wait == 0) begin
        bus.tx_done = 1'b1;
        last_done   = cyc;
        resp_wait   = -1;
      end
    end
  end

  // Monitor: pops the scoreboard on every DUT output event.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst_n) begin
      if (bus.tx_wr) begin
        check("tx_byte_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("tx_byte", 32'(bus.tx_data), 32'(e));
          if (first_byte) check("commit_to_tx_wr", cyc, commit_cyc + 1);
          else            check("done_to_tx_wr", cyc, last_done + 1);
          first_byte = 1'b0;
          bytes_seen++;
        end
        resp_wait = rand_delay ? int'($urandom_range(1, 6)) : resp_delay;
      end
      if (bus.pkt_sent) begin
        check("pkt_sent_expected", 32'(pkt_exp > 0), 32'd1);
        check("pkt_sent_frame_done", exp_q.size(), 0);
        check("busy_at_pkt_sent", 32'(bus.busy), 32'd0);
        check("done_to_pkt_sent", cyc, last_done + 1);
        if (pkt_exp > 0) pkt_exp--;
        mdl_busy = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mdl_write(input logic [7:0] b);
    if (!mdl_busy && mdl_buf.size() < MAX) mdl_buf.push_back(b);
    else mdl_err = 1'b1;
  endtask

  task automatic mdl_commit();
    if (!mdl_busy) begin
      exp_q.push_back(8'hD5);
      exp_q.push_back(8'(mdl_buf.size()));
      foreach (mdl_buf[k]) exp_q.push_back(mdl_buf[k]);
      exp_q.push_back(ref_crc(mdl_buf));
      mdl_buf.delete();
      mdl_busy   = 1'b1;
      mdl_err    = 1'b0;
      pkt_exp++;
      first_byte = 1'b1;
      commit_cyc = cyc;
      bytes_seen = 0;
    end
  endtask

  task automatic do_wr(input logic [7:0] b);
    bus.pl_data = b;
    bus.pl_wr   = 1'b1;
    mdl_write(b);
    step();
    bus.pl_wr   = 1'b0;
  endtask

  task automatic do_commit(input bit with_byte, input logic [7:0] b);
    bus.pl_commit = 1'b1;
    if (with_byte) begin
      bus.pl_wr   = 1'b1;
      bus.pl_data = b;
      mdl_write(b);
    end
    mdl_commit();
    step();
    bus.pl_commit = 1'b0;
    bus.pl_wr     = 1'b0;
  endtask

  task automatic do_abort();
    bus.pl_abort = 1'b1;
    if (!mdl_busy) begin
      mdl_buf.delete();
      mdl_err = 1'b0;
    end
    step();
    bus.pl_abort = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 5000 && mdl_busy; i++) step();
    check("frame_done_in_time", 32'(mdl_busy), 32'd0);
    repeat (2) step();
    check("busy_when_idle", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    int         n;
    bit         with_last;

    bus.pl_data   = 8'h00;
    bus.pl_wr     = 1'b0;
    bus.pl_commit = 1'b0;
    bus.pl_abort  = 1'b0;
    bus.tx_done   = 1'b0;

    repeat (3) step();
    check("rst_tx_wr", 32'(bus.tx_wr), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_pkt_sent", 32'(bus.pkt_sent), 32'd0);
    check("rst_err_overflow", 32'(bus.err_overflow), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    rst_n = 1'b1;
    step();

    // Single byte, slow UART.
    resp_delay = 100;
    rand_delay = 1'b0;
    do_wr(8'h81);
    do_commit(1'b0, 8'h00);
    check("busy_after_commit", 32'(bus.busy), 32'd1);
    wait_idle();

    // Last write coincides with commit.
    rand_delay = 1'b1;
    do_wr(8'h81);
    do_wr(8'hBA);
    do_commit(1'b1, 8'hCE);
    wait_idle();

    // Writes, commit and abort during transmission must not disturb the frame.
    do_wr(8'h50); do_wr(8'h00); do_wr(8'h00); do_wr(8'h00); do_wr(8'h80);
    do_commit(1'b0, 8'h00);
    repeat (3) step();
    do_wr(8'hAA);
    check("err_after_busy_write", 32'(bus.err_overflow), 32'(mdl_err));
    do_commit(1'b0, 8'h00);
    do_abort();
    wait_idle();
    repeat (5) step();

    // Overflow: MAX+1 bytes, the last one is dropped.
    do_abort();
    check("err_cleared_by_abort", 32'(bus.err_overflow), 32'(mdl_err));
    for (int i = 1; i <= MAX + 1; i++) do_wr(8'(i));
    check("err_after_overflow", 32'(bus.err_overflow), 32'd1);
    do_commit(1'b0, 8'h00);
    step();
    check("err_cleared_on_start", 32'(bus.err_overflow), 32'(mdl_err));
    wait_idle();

    // Empty frame, then abort discarding a byte.
    do_commit(1'b0, 8'h00);
    wait_idle();
    do_wr(8'h85);
    do_abort();
    do_wr(8'h85);
    do_commit(1'b0, 8'h00);
    wait_idle();

    // Reset in the middle of a frame.
    do_wr(8'h81); do_wr(8'hBA); do_wr(8'hCE);
    do_commit(1'b0, 8'h00);
    for (int i = 0; i < 2000 && bytes_seen < 2; i++) step();
    check("len_byte_seen", 32'(bytes_seen >= 2), 32'd1);
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_tx_wr", 32'(bus.tx_wr), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_tx_data", 32'(bus.tx_data), 32'd0);
    exp_q.delete();
    mdl_buf.delete();
    pkt_exp    = 0;
    mdl_busy   = 1'b0;
    mdl_err    = 1'b0;
    first_byte = 1'b0;
    repeat (3) step();
    check("inrst_tx_wr", 32'(bus.tx_wr), 32'd0);
    rst_n = 1'b1;
    step();
    do_wr(8'h81);
    do_commit(1'b0, 8'h00);
    wait_idle();

    // Randomized frames, including overflow and commit-with-last-byte.
    for (int f = 0; f < 10; f++) begin
      if ($urandom_range(0, 3) == 0) begin
        do_wr(8'($urandom));
        do_abort();
      end
      n = int'($urandom_range(0, MAX + 3));
      with_last = (n > 0) && ($urandom_range(0, 1) == 1);
      for (int i = 0; i < (with_last ? n - 1 : n); i++) do_wr(8'($urandom));
      check("rand_err_before_commit", 32'(bus.err_overflow), 32'(mdl_err));
      b = 8'($urandom);
      do_commit(with_last, b);
      wait_idle();
    end

    repeat (5) step();
    check("scoreboard_empty", exp_q.size(), 0);
    check("pkt_sent_all_seen", pkt_exp, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
